// File: rtl/rng_pkg.sv
// Shared definitions for the entropy-to-Wishbone core: register offsets,
// CTRL/STATUS bit positions and the FIFO word type.
package rng_pkg;
    typedef logic [31:0] word_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_BYPASS = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_CLR    = 3;

    localparam int STAT_NONEMPTY  = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_ALARM     = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_LEVEL_LSB = 4;
endpackage

// File: rtl/rng_wb_if.sv
// Wishbone slave bundle between the management SoC and the entropy core.
interface rng_wb_if;
    logic                 wbs_stb_i;
    logic                 wbs_cyc_i;
    logic                 wbs_we_i;
    logic [3:0]           wbs_sel_i;
    rng_pkg::word_t       wbs_dat_i;
    logic [31:0]          wbs_adr_i;
    logic                 wbs_ack_o;
    rng_pkg::word_t       wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/rng_fifo.sv
// Small synchronous word FIFO; storage is an array with a registered read port.
module rng_fifo
    import rng_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  word_t                    push_data,
    input  logic                     pop,
    output word_t                    pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    word_t          mem [DEPTH];
    word_t          rd_data_reg;
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    level_reg;
    logic           do_push;
    logic           do_pop;

    assign empty    = (level_reg == '0);
    assign full     = (level_reg == FULL_LEVEL);
    assign level    = level_reg;
    assign pop_data = rd_data_reg;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
        if (do_pop)  rd_data_reg     <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end
endmodule

// File: rtl/rng_wb_core.sv
// Ring-oscillator entropy sampler with debiaser, repetition health test,
// 32-bit word packer and a Wishbone-readable FIFO.
module rng_wb_core
    import rng_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          SAMPLE_DIV = 8,
    parameter int          REP_LIMIT  = 32,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic      wb_clk_i,
    input  logic      wb_rst_i,
    rng_wb_if.slave   wbs,
    input  logic      ent_i,
    output logic      irq_o
);
    localparam int SYNC_STAGES = 2;
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int REP_W = $clog2(REP_LIMIT + 1);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);

    logic             sync_reg [SYNC_STAGES];
    logic [DIV_W-1:0] div_cnt_reg;
    logic [2:0]       ctrl_reg;
    logic             pair_valid_reg, pair_first_reg;
    word_t            word_reg;
    logic [4:0]       bit_cnt_reg;
    logic             prev_reg;
    logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
    logic             alarm_reg, overflow_reg;
    logic             ack_reg, pop_rsp_reg;
    word_t            rdata_reg, rdata_next, status_word;

    logic en, bypass, sample, sample_en, emit, emit_bit, alarm_set;
    logic push_req, adr_match, req, wr, rd, ctrl_wr, clr, data_rd, pop_accepted, overflow_set;
    logic fifo_full, fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic [1:0] reg_off;
    word_t fifo_data, push_word;
    logic unused_bits;

    assign en     = ctrl_reg[CTRL_EN];
    assign bypass = ctrl_reg[CTRL_BYPASS];

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge wb_clk_i) begin
                    if (wb_rst_i) sync_reg[0] <= 1'b0;
                    else          sync_reg[0] <= ent_i;
                end
            end else begin : g_next
                always_ff @(posedge wb_clk_i) begin
                    if (wb_rst_i) sync_reg[gi] <= 1'b0;
                    else          sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate
    assign sample = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !en)          div_cnt_reg <= '0;
        else if (div_cnt_reg == DIV_LAST) div_cnt_reg <= '0;
        else                          div_cnt_reg <= div_cnt_reg + 1'b1;
    end
    assign sample_en = en && (div_cnt_reg == DIV_LAST);

    // Von Neumann pairs: the first bit of an unequal pair is the emitted value.
    always_comb begin
        emit     = 1'b0;
        emit_bit = sample;
        if (sample_en) begin
            if (bypass) begin
                emit = 1'b1;
            end else if (pair_valid_reg && (pair_first_reg != sample)) begin
                emit     = 1'b1;
                emit_bit = pair_first_reg;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !en) begin
            pair_valid_reg <= 1'b0;
            pair_first_reg <= 1'b0;
        end else if (sample_en && !bypass) begin
            pair_valid_reg <= !pair_valid_reg;
            pair_first_reg <= sample;
        end
    end

    assign push_word = {emit_bit, word_reg[31:1]};
    assign push_req  = emit && (bit_cnt_reg == 5'd31) && !alarm_reg;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            word_reg    <= '0;
            bit_cnt_reg <= '0;
        end else if (emit) begin
            word_reg    <= push_word;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        if (rep_cnt_reg == '0 || sample != prev_reg) rep_cnt_next = REP_W'(1);
        else if (rep_cnt_reg == REP_MAX)             rep_cnt_next = REP_MAX;
        else                                         rep_cnt_next = rep_cnt_reg + 1'b1;
    end
    assign alarm_set = sample_en && (rep_cnt_next == REP_MAX);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rep_cnt_reg <= '0;
            prev_reg    <= 1'b0;
        end else if (sample_en) begin
            rep_cnt_reg <= rep_cnt_next;
            prev_reg    <= sample;
        end
    end

    assign adr_match    = (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign req          = wbs.wbs_stb_i && wbs.wbs_cyc_i && adr_match && !ack_reg;
    assign reg_off      = wbs.wbs_adr_i[3:2];
    assign wr           = req && wbs.wbs_we_i;
    assign rd           = req && !wbs.wbs_we_i;
    assign ctrl_wr      = wr && (reg_off == REG_CTRL) && wbs.wbs_sel_i[0];
    assign clr          = ctrl_wr && wbs.wbs_dat_i[CTRL_CLR];
    assign data_rd      = rd && (reg_off == REG_DATA);
    assign pop_accepted = data_rd && !fifo_empty;
    assign overflow_set = push_req && fifo_full && !pop_accepted;
    // Bits the register map never looks at.
    assign unused_bits  = ^{wbs.wbs_sel_i[3:1], wbs.wbs_dat_i[31:4], wbs.wbs_adr_i[1:0]};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl_reg     <= '0;
            alarm_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl_reg <= wbs.wbs_dat_i[2:0];
            // A fresh event in the same cycle as clr keeps the flag set.
            if (alarm_set)    alarm_reg <= 1'b1;
            else if (clr)     alarm_reg <= 1'b0;
            if (overflow_set) overflow_reg <= 1'b1;
            else if (clr)     overflow_reg <= 1'b0;
        end
    end

    rng_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (wb_clk_i),
        .srst      (wb_rst_i),
        .push      (push_req),
        .push_data (push_word),
        .pop       (data_rd),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        status_word                                = '0;
        status_word[STAT_NONEMPTY]                 = !fifo_empty;
        status_word[STAT_FULL]                     = fifo_full;
        status_word[STAT_ALARM]                    = alarm_reg;
        status_word[STAT_OVERFLOW]                 = overflow_reg;
        status_word[STAT_LEVEL_LSB +: LVL_W]       = fifo_level;
        rdata_next = '0;
        case (reg_off)
            REG_CTRL:   rdata_next = {29'd0, ctrl_reg};
            REG_STATUS: rdata_next = status_word;
            default:    rdata_next = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_reg     <= 1'b0;
            pop_rsp_reg <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            ack_reg     <= req;
            pop_rsp_reg <= pop_accepted;
            rdata_reg   <= rd ? rdata_next : '0;
        end
    end

    assign wbs.wbs_ack_o = ack_reg;
    assign wbs.wbs_dat_o = !ack_reg ? '0 : (pop_rsp_reg ? fifo_data : rdata_reg);
    assign irq_o         = ctrl_reg[CTRL_IRQ_EN] && !fifo_empty;
endmodule

// File: tb/tb_rng_wb_core.sv
// Scoreboard bench for rng_wb_core: bus tasks queue expected read data, a
// negedge monitor checks every ack; a sample-level model predicts FIFO words.
module tb_rng_wb_core;
    import rng_pkg::*;

    localparam int          SAMPLE_DIV = 8;
    localparam int          REP_LIMIT  = 32;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [31:0] BASE       = 32'h3000_0000;

    typedef struct {
        string       name;
        logic [31:0] val;
        bit          chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ent = 1'b0;
    logic irq;
    int   checks = 0;
    int   fails  = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic ack_prev = 1'b0;

    logic [31:0] m_fifo[$];
    bit          m_alarm;
    bit          m_ovf;

    rng_wb_if wbs ();

    rng_wb_core #(
        .BASE_ADDR(BASE), .SAMPLE_DIV(SAMPLE_DIV),
        .REP_LIMIT(REP_LIMIT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (wbs),
        .ent_i    (ent),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    // Monitor: every ack pops one expected response.
    always @(negedge clk) begin
        if (!rst) begin
            if (wbs.wbs_ack_o) begin
                if (exp_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_ack: ack=1 data=%h, required no ack", wbs.wbs_dat_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.chk) begin
                        checks++;
                        if (wbs.wbs_dat_o !== mon_e.val) begin
                            fails++;
                            $display("FAIL %s: read %h, required %h", mon_e.name, wbs.wbs_dat_o, mon_e.val);
                        end else begin
                            $display("rd %s data=%h", mon_e.name, wbs.wbs_dat_o);
                        end
                    end else begin
                        $display("wr %s acked", mon_e.name);
                    end
                end
                checks++;
                if (ack_prev) begin
                    fails++;
                    $display("FAIL ack_width: ack high 2 cycles, required 1");
                end
            end else begin
                checks++;
                if (wbs.wbs_dat_o !== 32'h0) begin
                    fails++;
                    $display("FAIL dat_idle: dat_o=%h outside ack, required 0", wbs.wbs_dat_o);
                end
            end
        end
        ack_prev = wbs.wbs_ack_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic wb_cycle(input bit we, input logic [31:0] adr, input logic [31:0] wdat,
                            input logic [3:0] sel, input bit expect_ack,
                            input logic [31:0] exp_val, input string name);
        int n = 0;
        if (expect_ack) exp_q.push_back('{name, exp_val, !we});
        @(posedge clk); #1;
        wbs.wbs_adr_i = adr; wbs.wbs_dat_i = wdat; wbs.wbs_sel_i = sel;
        wbs.wbs_we_i = we; wbs.wbs_stb_i = 1'b1; wbs.wbs_cyc_i = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wbs.wbs_ack_o && n < 8);
        checks++;
        if (expect_ack && (!wbs.wbs_ack_o || n != 1)) begin
            fails++;
            $display("FAIL %s_ack: ack=%0b after %0d cycles, required ack after 1", name, wbs.wbs_ack_o, n);
            if (!wbs.wbs_ack_o) exp_q.pop_back();
        end else if (!expect_ack && wbs.wbs_ack_o) begin
            fails++;
            $display("FAIL %s_noack: ack=1, required no ack within 8 cycles", name);
        end else if (!expect_ack) begin
            $display("xfer %s adr=%h not acked", name, adr);
        end
        wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0; wbs.wbs_we_i = 1'b0;
    endtask

    function automatic logic [31:0] adr_of(input logic [1:0] off);
        return BASE | {28'd0, off, 2'b00};
    endfunction

    task automatic wr(input logic [1:0] off, input logic [31:0] d, input string name);
        wb_cycle(1'b1, adr_of(off), d, 4'hF, 1'b1, 32'h0, name);
    endtask

    task automatic rd(input logic [1:0] off, input logic [31:0] exp, input string name);
        wb_cycle(1'b0, adr_of(off), 32'h0, 4'hF, 1'b1, exp, name);
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s = '0;
        s[0]   = (m_fifo.size() != 0);
        s[1]   = (m_fifo.size() == FIFO_DEPTH);
        s[2]   = m_alarm;
        s[3]   = m_ovf;
        s[7:4] = 4'(m_fifo.size());
        return s;
    endfunction

    task automatic rd_data(input string name);
        logic [31:0] e = 32'h0;
        if (m_fifo.size() != 0) e = m_fifo.pop_front();
        rd(REG_DATA, e, name);
    endtask

    // Reference: derive emitted bits, alarm point and FIFO contents from the sample list.
    task automatic model_phase(input bit bits[$], input bit bypass);
        int alarm_at = -1;
        int run = 0;
        bit emit_val[$];
        int emit_src[$];
        logic [31:0] w;
        for (int i = 0; i < bits.size(); i++) begin
            run = (i > 0 && bits[i] == bits[i-1]) ? run + 1 : 1;
            if (run >= REP_LIMIT && alarm_at < 0) alarm_at = i;
        end
        if (bypass) begin
            for (int i = 0; i < bits.size(); i++) begin
                emit_val.push_back(bits[i]); emit_src.push_back(i);
            end
        end else begin
            for (int i = 1; i < bits.size(); i += 2)
                if (bits[i-1] != bits[i]) begin
                    emit_val.push_back(bits[i-1]); emit_src.push_back(i);
                end
        end
        if (alarm_at >= 0) m_alarm = 1'b1;
        for (int k = 0; (k + 1) * 32 <= emit_val.size(); k++) begin
            if (alarm_at >= 0 && emit_src[k*32+31] > alarm_at) continue;
            w = '0;
            for (int j = 0; j < 32; j++) w[j] = emit_val[k*32+j];
            if (m_fifo.size() == FIFO_DEPTH) m_ovf = 1'b1;
            else                             m_fifo.push_back(w);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        m_fifo.delete(); m_alarm = 1'b0; m_ovf = 1'b0;
    endtask

    // Each bit is held for one divider period, centred on its sample point.
    task automatic run_phase(input logic [2:0] ctrl, input bit bits[$]);
        ent = bits[0];
        wr(REG_CTRL, {29'd0, ctrl}, "ctrl_on");
        repeat (2) @(posedge clk);
        #1;
        foreach (bits[k]) begin
            ent = bits[k];
            repeat (SAMPLE_DIV) @(posedge clk);
            #1;
        end
        wr(REG_CTRL, {29'd0, ctrl & 3'b110}, "ctrl_off");
        model_phase(bits, ctrl[1]);
    endtask

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        bit bits[$];
        int n, p;
        bit byp;
        wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0; wbs.wbs_we_i = 1'b0;
        wbs.wbs_sel_i = 4'h0; wbs.wbs_dat_i = 32'h0; wbs.wbs_adr_i = 32'h0;

        do_reset();
        check("irq_reset", {31'd0, irq}, 32'h0);
        check("ack_reset", {31'd0, wbs.wbs_ack_o}, 32'h0);
        rd(REG_STATUS, m_status(), "status_reset");
        rd(REG_CTRL, 32'h0, "ctrl_reset");

        // Alternating 1,0 in bypass.
        bits.delete();
        for (int i = 0; i < 32; i++) bits.push_back(i % 2 == 0);
        run_phase(3'b011, bits);
        rd(REG_STATUS, m_status(), "status_alt");
        rd_data("data_alt");
        rd(REG_STATUS, m_status(), "status_alt_drained");

        // Debiased pairs 10,10,00,01.
        do_reset();
        bits.delete();
        for (int g = 0; g < 11; g++) begin
            bits.push_back(1); bits.push_back(0); bits.push_back(1); bits.push_back(0);
            bits.push_back(0); bits.push_back(0); bits.push_back(0); bits.push_back(1);
        end
        run_phase(3'b001, bits);
        rd(REG_STATUS, m_status(), "status_vn");
        rd_data("data_vn");

        // Stuck-at-1 raises alarm and blocks later words.
        do_reset();
        bits.delete();
        for (int i = 0; i < 72; i++) bits.push_back(1);
        run_phase(3'b011, bits);
        rd(REG_STATUS, m_status(), "status_alarm");
        wr(REG_CTRL, 32'h8, "ctrl_clr");
        m_alarm = 1'b0;
        rd(REG_STATUS, m_status(), "status_cleared");
        rd(REG_CTRL, 32'h0, "ctrl_clr_reads0");
        wr(REG_CTRL, 32'h4, "ctrl_irq_en");
        check("irq_nonempty", {31'd0, irq}, {31'd0, m_fifo.size() != 0});
        rd_data("data_alarm");
        check("irq_empty", {31'd0, irq}, {31'd0, m_fifo.size() != 0});

        // Five words with no reads: overflow.
        do_reset();
        bits.delete();
        for (int i = 0; i < 160; i++) bits.push_back(1'($urandom_range(0, 1)));
        run_phase(3'b011, bits);
        rd(REG_STATUS, m_status(), "status_ovf");
        for (int i = 0; i < 5; i++) rd_data($sformatf("data_ovf%0d", i));
        rd(REG_STATUS, m_status(), "status_ovf_drained");

        // Randomised phases, one of them biased towards long runs.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            bits.delete();
            n   = $urandom_range(40, 260);
            p   = (r == 2) ? 98 : 0;
            byp = 1'($urandom_range(0, 1));
            bits.push_back(1'($urandom_range(0, 1)));
            for (int i = 1; i < n; i++)
                bits.push_back(($urandom_range(0, 99) < p) ? bits[i-1] : 1'($urandom_range(0, 1)));
            run_phase({1'b0, byp, 1'b1}, bits);
            rd(REG_STATUS, m_status(), $sformatf("status_rand%0d", r));
            n = m_fifo.size() + 1;
            for (int i = 0; i < n; i++) rd_data($sformatf("data_rand%0d_%0d", r, i));
        end

        // Register-map boundaries.
        do_reset();
        wr(REG_STATUS, 32'hFF, "status_write");
        rd(REG_STATUS, m_status(), "status_ro");
        wr(2'd3, 32'hFFFF_FFFF, "rsvd_write");
        rd(2'd3, 32'h0, "rsvd_read");
        wb_cycle(1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b0, 32'h0, "badadr_rd");
        wb_cycle(1'b1, BASE + 32'h10, 32'h7, 4'hF, 1'b0, 32'h0, "badadr_wr");
        wb_cycle(1'b1, adr_of(REG_CTRL), 32'h6, 4'hE, 1'b1, 32'h0, "ctrl_nosel");
        rd(REG_CTRL, 32'h0, "ctrl_sel_ignored");
        wr(REG_CTRL, 32'h6, "ctrl_write");
        rd(REG_CTRL, 32'h6, "ctrl_readback");

        repeat (4) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
